// File: rtl/alu_pkg.sv
// Shared ALU package: control codes, MIPS opcode/funct constants and the decoded bundle.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1101;
    localparam logic [3:0] ALU_SRL = 4'b1110;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic [3:0]  alu_ctrl;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        use_imm;
        logic [31:0] imm;
        logic        illegal;
    } dec_bundle_t;

endpackage

// File: rtl/alu_op_decode_comb.sv
// Pure combinational MIPS instruction -> ALU bundle decode.
// Define ALU_DEC_ITYPE_EN to add addi/slti/andi/ori decodes.
module alu_op_decode_comb
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output dec_bundle_t bundle
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] sext;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign sext  = {{16{instr[15]}}, instr[15:0]};

    always_comb begin
        bundle    = '0;
        bundle.rs = instr[25:21];
        bundle.rt = instr[20:16];
        bundle.rd = instr[20:16];
        case (op)
            OP_RTYPE: begin
                bundle.rd = instr[15:11];
                case (funct)
                    FN_ADD, FN_ADDU: bundle.alu_ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: bundle.alu_ctrl = ALU_SUB;
                    FN_AND:          bundle.alu_ctrl = ALU_AND;
                    FN_OR:           bundle.alu_ctrl = ALU_OR;
                    FN_NOR:          bundle.alu_ctrl = ALU_NOR;
                    FN_SLT:          bundle.alu_ctrl = ALU_SLT;
                    FN_SLL: begin
                        bundle.alu_ctrl = ALU_SLL;
                        bundle.shamt    = instr[10:6];
                    end
                    FN_SRL: begin
                        bundle.alu_ctrl = ALU_SRL;
                        bundle.shamt    = instr[10:6];
                    end
                    default:         bundle.illegal  = 1'b1;
                endcase
            end
            OP_LW, OP_SW: begin
                bundle.alu_ctrl = ALU_ADD;
                bundle.use_imm  = 1'b1;
                bundle.imm      = sext;
            end
            // beq compares registers; the offset travels along for the branch unit
            OP_BEQ: begin
                bundle.alu_ctrl = ALU_SUB;
                bundle.imm      = sext;
            end
`ifdef ALU_DEC_ITYPE_EN
            OP_ADDI: begin
                bundle.alu_ctrl = ALU_ADD;
                bundle.use_imm  = 1'b1;
                bundle.imm      = sext;
            end
            OP_SLTI: begin
                bundle.alu_ctrl = ALU_SLT;
                bundle.use_imm  = 1'b1;
                bundle.imm      = sext;
            end
            OP_ANDI: begin
                bundle.alu_ctrl = ALU_AND;
                bundle.use_imm  = 1'b1;
                bundle.imm      = {16'h0000, instr[15:0]};
            end
            OP_ORI: begin
                bundle.alu_ctrl = ALU_OR;
                bundle.use_imm  = 1'b1;
                bundle.imm      = {16'h0000, instr[15:0]};
            end
`endif
            default: bundle.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_decoder.sv
// Decode stage: valid/ready in, registered skid-buffered bundle out, illegal counter.
// Optional I-type decodes controlled by ALU_DEC_ITYPE_EN (see alu_op_decode_comb).
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_ctrl,
    output logic [4:0]       shamt,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic             use_imm,
    output logic [31:0]      imm,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    dec_bundle_t dec;
    dec_bundle_t out_reg;
    dec_bundle_t skid_reg;
    logic        skid_full;
    logic        in_xfer;
    logic        out_free;

    alu_op_decode_comb u_decode (
        .instr  (instr),
        .bundle (dec)
    );

    assign in_ready = ~skid_full;
    assign in_xfer  = in_valid & ~skid_full;
    assign out_free = ~out_valid | out_ready;

    // Skid is only ever filled while the output is held, so it always drains first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg   <= '0;
            skid_reg  <= '0;
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (out_free) begin
            if (skid_full) begin
                out_reg   <= skid_reg;
                out_valid <= 1'b1;
                skid_full <= 1'b0;
            end else if (in_xfer) begin
                out_reg   <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_reg  <= dec;
            skid_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (in_xfer && dec.illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    assign alu_ctrl = out_reg.alu_ctrl;
    assign shamt    = out_reg.shamt;
    assign rs       = out_reg.rs;
    assign rt       = out_reg.rt;
    assign rd       = out_reg.rd;
    assign use_imm  = out_reg.use_imm;
    assign imm      = out_reg.imm;
    assign illegal  = out_reg.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed self-checking bench for alu_op_decoder (default and CNT_W=2 instances).
module tb_alu_op_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        use_imm;
    logic [31:0] imm;
    logic        illegal;
    logic [15:0] illegal_cnt;

    logic        in_valid2;
    logic        in_ready2;
    logic [31:0] instr2;
    logic        out_valid2;
    logic [3:0]  alu_ctrl2;
    logic [4:0]  shamt2;
    logic [4:0]  rs2;
    logic [4:0]  rt2;
    logic [4:0]  rd2;
    logic        use_imm2;
    logic [31:0] imm2;
    logic        illegal2;
    logic [1:0]  illegal_cnt2;

    int unsigned tests;
    int unsigned fails;

    alu_op_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_ctrl    (alu_ctrl),
        .shamt       (shamt),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .use_imm     (use_imm),
        .imm         (imm),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    alu_op_decoder #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid2),
        .in_ready    (in_ready2),
        .instr       (instr2),
        .out_valid   (out_valid2),
        .out_ready   (1'b1),
        .alu_ctrl    (alu_ctrl2),
        .shamt       (shamt2),
        .rs          (rs2),
        .rt          (rt2),
        .rd          (rd2),
        .use_imm     (use_imm2),
        .imm         (imm2),
        .illegal     (illegal2),
        .illegal_cnt (illegal_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        instr    = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = '0;
        out_ready = 1'b1;
        in_valid2 = 1'b0;
        instr2    = '0;

        // reset state
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_cnt", {16'd0, illegal_cnt}, 32'd0);
        check("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("rst_imm", imm, 32'd0);
        rst = 1'b0;
        tick();

        // add $8,$9,$10
        send(32'h012A4020);
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_ctrl", {28'd0, alu_ctrl}, 32'h2);
        check("add_rs", {27'd0, rs}, 32'd9);
        check("add_rt", {27'd0, rt}, 32'd10);
        check("add_rd", {27'd0, rd}, 32'd8);
        check("add_use_imm", {31'd0, use_imm}, 32'd0);
        tick();
        check("add_drained", {31'd0, out_valid}, 32'd0);

        // sll $8,$9,2
        send(32'h00094080);
        check("sll_ctrl", {28'd0, alu_ctrl}, 32'hD);
        check("sll_shamt", {27'd0, shamt}, 32'd2);
        check("sll_rd", {27'd0, rd}, 32'd8);

        // lw $8,-4($9)
        send(32'h8D28FFFC);
        check("lw_ctrl", {28'd0, alu_ctrl}, 32'h2);
        check("lw_use_imm", {31'd0, use_imm}, 32'd1);
        check("lw_imm", imm, 32'hFFFFFFFC);
        check("lw_shamt", {27'd0, shamt}, 32'd0);
        check("lw_rd", {27'd0, rd}, 32'd8);

        // back-to-back with out_ready=1: no bubble
        send(32'h012A4024);
        check("b2b_and", {28'd0, alu_ctrl}, 32'h0);
        send(32'h012A4025);
        check("b2b_or", {28'd0, alu_ctrl}, 32'h1);
        check("b2b_valid", {31'd0, out_valid}, 32'd1);
        tick();

        // back-pressure: A=add, B=sub
        out_ready = 1'b0;
        send(32'h012A4020);
        check("bp_a_valid", {31'd0, out_valid}, 32'd1);
        check("bp_a_ready", {31'd0, in_ready}, 32'd1);
        send(32'h012A4022);
        check("bp_b_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_a", {28'd0, alu_ctrl}, 32'h2);
        instr    = 32'h012A4025;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_hold_a2", {28'd0, alu_ctrl}, 32'h2);
        out_ready = 1'b1;
        tick();
        check("bp_b_out", {28'd0, alu_ctrl}, 32'h6);
        check("bp_b_valid", {31'd0, out_valid}, 32'd1);
        check("bp_ready_back", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // illegal x3
        check("cnt_before_ill", {16'd0, illegal_cnt}, 32'd0);
        send(32'hFC000000);
        check("ill1", {31'd0, illegal}, 32'd1);
        send(32'hFC000000);
        check("ill2", {31'd0, illegal}, 32'd1);
        send(32'hFC000000);
        check("ill3", {31'd0, illegal}, 32'd1);
        check("ill_ctrl", {28'd0, alu_ctrl}, 32'h0);
        check("ill_imm", imm, 32'd0);
        check("ill_cnt3", {16'd0, illegal_cnt}, 32'd3);

        // ori $8,$9,0xF
        send(32'h3528000F);
`ifdef ALU_DEC_ITYPE_EN
        check("ori_ctrl", {28'd0, alu_ctrl}, 32'h1);
        check("ori_use_imm", {31'd0, use_imm}, 32'd1);
        check("ori_imm", imm, 32'h0000000F);
        check("ori_illegal", {31'd0, illegal}, 32'd0);
        check("ori_cnt", {16'd0, illegal_cnt}, 32'd3);
`else
        check("ori_illegal", {31'd0, illegal}, 32'd1);
        check("ori_ctrl", {28'd0, alu_ctrl}, 32'h0);
        check("ori_cnt", {16'd0, illegal_cnt}, 32'd4);
`endif
        tick();

        // CNT_W=2 saturation
        instr2    = 32'hFC000000;
        in_valid2 = 1'b1;
        tick();
        tick();
        check("sat_cnt2", {30'd0, illegal_cnt2}, 32'd2);
        tick();
        tick();
        tick();
        in_valid2 = 1'b0;
        check("sat_cnt5", {30'd0, illegal_cnt2}, 32'd3);

        // async reset with both entries full
        out_ready = 1'b0;
        send(32'h012A4020);
        send(32'h012A4022);
        check("pre_rst_ready", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_cnt", {16'd0, illegal_cnt}, 32'd0);
        check("mid_rst_ctrl", {28'd0, alu_ctrl}, 32'h0);
        check("mid_rst_rs", {27'd0, rs}, 32'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        send(32'h012A4022);
        check("post_rst_sub", {28'd0, alu_ctrl}, 32'h6);
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
